// File: rtl/lock_pkg.sv
// Shared types and helpers for the door-lock sequencer.
// State encoding, keypad constants and small compile-time utilities.
package lock_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      CHECK,
      OPENING,
      HOLD,
      CLOSING,
      LOCKOUT,
      PROG
   } state_e;

   localparam logic [3:0] KEY_STAR = 4'hA;
   localparam logic [3:0] KEY_HASH = 4'hB;

   function automatic logic is_digit(input logic [3:0] key);
      return (key <= 4'd9);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int max4(input int a, input int b,
                               input int c, input int d);
      return max2(max2(a, b), max2(c, d));
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by all timed lock states.
// Holds at zero; expired is high whenever the count is zero.
module lock_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// PIN-entry door-lock controller driving the lock motor.
// Define LOCK_CODE_PROG_EN to allow re-programming the PIN while unlocked.
module lock_sequencer
   import lock_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h1234,
   parameter int MOTOR_CYCLES = 1000,
   parameter int HOLD_CYCLES = 5000,
   parameter int MAX_FAIL = 3,
   parameter int LOCKOUT_CYCLES = 20000,
   parameter int ENTRY_TIMEOUT = 8000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       motor_en,
   output logic       motor_dir,
   output logic       unlocked,
   output logic       locked_out,
   output logic [3:0] fail_cnt,
   output logic [3:0] digit_cnt
);

   localparam int CW = 4 * DIGITS;
   localparam int TMAX = max4(MOTOR_CYCLES, HOLD_CYCLES,
                              LOCKOUT_CYCLES, ENTRY_TIMEOUT);
   localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [3:0] DIG_MAX = 4'(DIGITS);
   localparam logic [3:0] FAIL_MAX = 4'(MAX_FAIL);

   state_e state_q;
   state_e state_d;

   logic          kv_q;
   logic [3:0]    kc_q;
   logic [CW-1:0] buf_q;
   logic [CW-1:0] buf_d;
   logic [3:0]    dcnt_q;
   logic [3:0]    dcnt_d;
   logic [3:0]    fail_q;
   logic [3:0]    fail_d;

   logic motor_en_q;
   logic motor_dir_q;
   logic unl_q;
   logic lock_q;

   logic          reload;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_exp;
   logic [CW-1:0] code;

   logic key_dig;
   logic key_star;
   logic key_hash;
   logic full;
   logic match;

`ifdef LOCK_CODE_PROG_EN
   logic          code_we;
   logic [CW-1:0] code_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         code_q <= DEFAULT_CODE;
      end else if (code_we) begin
         code_q <= buf_q;
      end
   end

   assign code = code_q;
`else
   assign code = DEFAULT_CODE;
`endif

   function automatic logic [CW-1:0] shift_in(
      input logic [CW-1:0] b,
      input logic [3:0]    k
   );
      return (b << 4) | CW'(k);
   endfunction

   // Keys are registered once before the FSM sees them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         kv_q <= 1'b0;
         kc_q <= 4'h0;
      end else begin
         kv_q <= key_valid;
         kc_q <= key_code;
      end
   end

   assign key_dig  = kv_q && is_digit(kc_q);
   assign key_star = kv_q && (kc_q == KEY_STAR);
   assign key_hash = kv_q && (kc_q == KEY_HASH);
   assign full     = (dcnt_q == DIG_MAX);
   assign match    = full && (buf_q == code);

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      dcnt_d  = dcnt_q;
      fail_d  = fail_q;
      reload  = 1'b0;
`ifdef LOCK_CODE_PROG_EN
      code_we = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (key_dig) begin
               buf_d   = shift_in(buf_q, kc_q);
               dcnt_d  = 4'd1;
               state_d = ENTRY;
            end
         end
         ENTRY: begin
            if (key_dig && !full) begin
               buf_d  = shift_in(buf_q, kc_q);
               dcnt_d = dcnt_q + 4'd1;
               reload = 1'b1;
            end else if (key_star) begin
               buf_d   = '0;
               dcnt_d  = 4'd0;
               state_d = IDLE;
            end else if (key_hash) begin
               state_d = CHECK;
            end else if (tmr_exp) begin
               buf_d   = '0;
               dcnt_d  = 4'd0;
               state_d = IDLE;
            end
         end
         CHECK: begin
            buf_d  = '0;
            dcnt_d = 4'd0;
            if (match) begin
               fail_d  = 4'd0;
               state_d = OPENING;
            end else if (fail_q + 4'd1 == FAIL_MAX) begin
               fail_d  = FAIL_MAX;
               state_d = LOCKOUT;
            end else begin
               fail_d  = fail_q + 4'd1;
               state_d = IDLE;
            end
         end
         OPENING: begin
            if (tmr_exp) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
`ifdef LOCK_CODE_PROG_EN
            if (key_hash) begin
               buf_d   = '0;
               dcnt_d  = 4'd0;
               state_d = PROG;
            end else if (tmr_exp) begin
               state_d = CLOSING;
            end
`else
            if (tmr_exp) begin
               state_d = CLOSING;
            end
`endif
         end
         CLOSING: begin
            if (tmr_exp) begin
               state_d = IDLE;
            end
         end
         LOCKOUT: begin
            if (tmr_exp) begin
               fail_d  = 4'd0;
               state_d = IDLE;
            end
         end
         PROG: begin
`ifdef LOCK_CODE_PROG_EN
            if (key_dig && !full) begin
               buf_d  = shift_in(buf_q, kc_q);
               dcnt_d = dcnt_q + 4'd1;
               reload = 1'b1;
            end else if (key_hash || key_star || tmr_exp) begin
               code_we = key_hash && full;
               buf_d   = '0;
               dcnt_d  = 4'd0;
               state_d = CLOSING;
            end
`else
            state_d = IDLE;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Timer is armed with N-1 on every state entry so each state lasts N cycles.
   assign tmr_load = (state_d != state_q) || reload;

   always_comb begin
      tmr_val = '0;
      unique case (state_d)
         ENTRY, PROG:       tmr_val = TW'(ENTRY_TIMEOUT - 1);
         OPENING, CLOSING:  tmr_val = TW'(MOTOR_CYCLES - 1);
         HOLD:              tmr_val = TW'(HOLD_CYCLES - 1);
         LOCKOUT:           tmr_val = TW'(LOCKOUT_CYCLES - 1);
         default:           tmr_val = '0;
      endcase
   end

   lock_timer #(
      .W (TW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expired_o  (tmr_exp)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         buf_q   <= '0;
         dcnt_q  <= 4'd0;
         fail_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         dcnt_q  <= dcnt_d;
         fail_q  <= fail_d;
      end
   end

   // Outputs are decoded from the next state so they align with state_q.
   always_ff @(posedge clk) begin
      if (!rst) begin
         motor_en_q  <= 1'b0;
         motor_dir_q <= 1'b0;
         unl_q       <= 1'b0;
         lock_q      <= 1'b0;
      end else begin
         motor_en_q  <= (state_d == OPENING) || (state_d == CLOSING);
         motor_dir_q <= (state_d == OPENING);
         unl_q       <= (state_d == HOLD) || (state_d == PROG);
         lock_q      <= (state_d == LOCKOUT);
      end
   end

   assign motor_en   = motor_en_q;
   assign motor_dir  = motor_dir_q;
   assign unlocked   = unl_q;
   assign locked_out = lock_q;
   assign fail_cnt   = fail_q;
   assign digit_cnt  = dcnt_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed scoreboard bench for lock_sequencer with short timing parameters.
// Honours LOCK_CODE_PROG_EN to exercise PIN re-programming.
module tb_lock_sequencer;
   import lock_pkg::*;

   localparam int M  = 5;
   localparam int H  = 20;
   localparam int L  = 11;
   localparam int ET = 9;
   localparam int MF = 3;

`ifdef LOCK_CODE_PROG_EN
   localparam logic [3:0] HOLD_KEY = 4'd5;
`else
   localparam logic [3:0] HOLD_KEY = KEY_HASH;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       motor_en;
   logic       motor_dir;
   logic       unlocked;
   logic       locked_out;
   logic [3:0] fail_cnt;
   logic [3:0] digit_cnt;

   always #5 clk = ~clk;

   lock_sequencer #(
      .DIGITS         (4),
      .DEFAULT_CODE   (16'h1234),
      .MOTOR_CYCLES   (M),
      .HOLD_CYCLES    (H),
      .MAX_FAIL       (MF),
      .LOCKOUT_CYCLES (L),
      .ENTRY_TIMEOUT  (ET)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .motor_en   (motor_en),
      .motor_dir  (motor_dir),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .fail_cnt   (fail_cnt),
      .digit_cnt  (digit_cnt)
   );

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void want(input string t, input int v);
      exp_t e;
      e.tag = t;
      e.v   = 32'(v);
      sb.push_back(e);
   endfunction

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $error("FAIL sb_empty observed=%0d expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.v) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic press(input logic [3:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic keys(input string s);
      byte c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         if (c == "*") press(KEY_STAR);
         else if (c == "#") press(KEY_HASH);
         else press(4'(c - 8'd48));
      end
   endtask

   task automatic chk_zero_outputs(input string p);
      want({p, "_men"}, 0);
      want({p, "_mdir"}, 0);
      want({p, "_unl"}, 0);
      want({p, "_lock"}, 0);
      want({p, "_fail"}, 0);
      want({p, "_dcnt"}, 0);
      chk(32'(motor_en));
      chk(32'(motor_dir));
      chk(32'(unlocked));
      chk(32'(locked_out));
      chk(32'(fail_cnt));
      chk(32'(digit_cnt));
   endtask

   // Called right after the '#' press returns (negedge after its sampling edge).
   task automatic open_seq(input bit prog);
      int n;
      want("rise_lat", 2);
      want("open_len", M);
      n = 0;
      while (motor_en !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(32'(n));
      n = 0;
      while (motor_en === 1'b1 && motor_dir === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(32'(n));
      if (!prog) begin
         want("hold_len", H);
         n = 0;
         while (unlocked === 1'b1 && motor_en === 1'b0 && n < 100) begin
            key_valid = (n == 2);
            key_code  = HOLD_KEY;
            @(negedge clk);
            n++;
         end
         key_valid = 1'b0;
         chk(32'(n));
      end else begin
         keys("#9876");
         want("prog_unl", 1);
         chk(32'(unlocked));
         keys("#");
         n = 0;
         while (motor_en !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      want("close_len", M);
      n = 0;
      while (motor_en === 1'b1 && motor_dir === 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(32'(n));
      want("end_unl", 0);
      want("end_dir", 0);
      want("end_fail", 0);
      chk(32'(unlocked));
      chk(32'(motor_dir));
      chk(32'(fail_cnt));
   endtask

   initial begin
      int n;

      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst = 1'b1;

      keys("1234");
      @(negedge clk);
      want("dcnt_full", 4);
      chk(32'(digit_cnt));
      keys("#");
      open_seq(1'b0);

      for (int i = 1; i <= MF; i++) begin
         keys("1235#");
         repeat (2) @(negedge clk);
         want("fail_step", i);
         chk(32'(fail_cnt));
      end
      want("lock_on", 1);
      chk(32'(locked_out));
      n = 0;
      while (locked_out === 1'b1 && n < 200) begin
         key_valid = (n < 4);
         key_code  = 4'(n + 1);
         @(negedge clk);
         n++;
      end
      key_valid = 1'b0;
      want("lock_len", L);
      want("lock_dcnt", 0);
      want("lock_fail", 0);
      chk(32'(n));
      chk(32'(digit_cnt));
      chk(32'(fail_cnt));
      keys("1234#");
      open_seq(1'b0);

      keys("12#");
      repeat (2) @(negedge clk);
      want("short_fail", 1);
      chk(32'(fail_cnt));
      keys("12345");
      @(negedge clk);
      want("sat_dcnt", 4);
      chk(32'(digit_cnt));
      keys("#");
      open_seq(1'b0);

      keys("9#");
      repeat (2) @(negedge clk);
      want("pre_star_fail", 1);
      chk(32'(fail_cnt));
      keys("12*");
      @(negedge clk);
      want("star_dcnt", 0);
      want("star_fail", 1);
      chk(32'(digit_cnt));
      chk(32'(fail_cnt));
      keys("1234#");
      open_seq(1'b0);

      keys("5#");
      repeat (2) @(negedge clk);
      want("pre_to_fail", 1);
      chk(32'(fail_cnt));
      keys("12");
      repeat (ET) @(negedge clk);
      want("to_edge_dcnt", 2);
      chk(32'(digit_cnt));
      @(negedge clk);
      want("to_dcnt", 0);
      want("to_fail", 1);
      chk(32'(digit_cnt));
      chk(32'(fail_cnt));

      keys("1234#");
      n = 0;
      while (motor_en !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      want("pre_rst_men", 1);
      chk(32'(motor_en));
      rst = 1'b0;
      @(negedge clk);
      chk_zero_outputs("midrst");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      n = 0;
      repeat (3 * M) begin
         @(negedge clk);
         if (motor_en !== 1'b0) n++;
      end
      want("no_close", 0);
      chk(32'(n));

`ifdef LOCK_CODE_PROG_EN
      keys("1234#");
      open_seq(1'b1);
      keys("1234#");
      repeat (2) @(negedge clk);
      want("old_code_fail", 1);
      chk(32'(fail_cnt));
      keys("9876#");
      open_seq(1'b0);
`endif

      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Door-lock controller between the keypad scanner and the motor driver.
- Collects PIN digits from decoded key events and compares them against the stored code.
- On a match, sequences the motor open, holds the door unlocked, then sequences the motor closed.
- Counts failed attempts and enforces a timed lockout; replaces the ad-hoc motor-enable bit the CPU drives today.

Parameters:
- DIGITS, 4, PIN length in digits (1..8).
- DEFAULT_CODE, 16'h1234, reset PIN, packed BCD with the first-entered digit in the MS nibble; width 4*DIGITS.
- MOTOR_CYCLES, 1000, cycles motor_en stays high per open/close stroke (>=1).
- HOLD_CYCLES, 5000, cycles the door stays unlocked (>=1).
- MAX_FAIL, 3, consecutive failures that trigger lockout (1..15).
- LOCKOUT_CYCLES, 20000, lockout duration (>=1).
- ENTRY_TIMEOUT, 8000, idle cycles in ENTRY before the buffer is discarded (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- key_valid  in  1  one-cycle pulse: key_code is valid.
- key_code  in  4  0-9 digit, 4'hA '*' (clear), 4'hB '#' (enter); 4'hC-F are ignored.
- motor_en  out  1  motor drive enable.
- motor_dir  out  1  1=open, 0=close; meaningful only when motor_en=1.
- unlocked  out  1  door held open.
- locked_out  out  1  lockout active.
- fail_cnt  out  4  consecutive failed attempts.
- digit_cnt  out  4  digits currently buffered.

Behaviour:
- Reset (rst=0 sampled at a clk edge):
  - state IDLE; all outputs 0; digit buffer cleared; code_reg=DEFAULT_CODE; all timers cleared.
  - Reset mid-stroke drops motor_en on the next edge; no close stroke is performed.
- Keys are accepted only in IDLE/ENTRY (and PROG, optional feature). They are ignored in CHECK, OPENING, HOLD, CLOSING, LOCKOUT.
- IDLE:
  - Digit: shift into buffer (buf <= {buf, digit}, MS nibbles drop), digit_cnt=1, go to ENTRY.
  - '*' or '#': no effect.
- ENTRY:
  - Digit with digit_cnt<DIGITS: shift in, digit_cnt++.
  - Digit with digit_cnt==DIGITS: ignored; count saturates, buffer unchanged.
  - '*': clear buffer and digit_cnt, go to IDLE; not counted as a failure.
  - '#': go to CHECK. A '#' with digit_cnt<DIGITS is a guaranteed mismatch.
  - Each accepted key reloads the entry timer. Timer expiry after ENTRY_TIMEOUT cycles with no key: clear buffer, go to IDLE, no failure.
- CHECK: exactly 1 cycle; buffer and digit_cnt are cleared on exit.
  - Match (digit_cnt==DIGITS && buf==code_reg): fail_cnt=0, go to OPENING.
  - Mismatch, fail_cnt+1==MAX_FAIL: fail_cnt=MAX_FAIL, go to LOCKOUT.
  - Mismatch otherwise: fail_cnt++, go to IDLE.
- OPENING: motor_en=1, motor_dir=1 for exactly MOTOR_CYCLES cycles, then HOLD.
  - motor_en first rises 2 cycles after the edge that samples '#'.
- HOLD: unlocked=1 for exactly HOLD_CYCLES cycles, then CLOSING.
- CLOSING: motor_en=1, motor_dir=0 for exactly MOTOR_CYCLES cycles, then IDLE.
- LOCKOUT: locked_out=1 for LOCKOUT_CYCLES cycles, then fail_cnt=0, go to IDLE.
- Timer: one shared down-counter, loaded on state entry with N-1 and expiring at 0, so each timed state lasts exactly N cycles.
- Output encoding:
  - motor_en and motor_dir are registered, decoded from the next state, with no glitch between OPENING and HOLD.
  - motor_dir is 0 whenever motor_en is 0.
- key_valid asserted on the same edge as a state change is evaluated in the state being left.

Optional Feature:
- Macro: LOCK_CODE_PROG_EN.
- Enabled:
  - '#' in HOLD enters PROG: unlocked stays 1, motor idle, buffer cleared.
  - Digits are collected as in ENTRY.
  - '#' with digit_cnt==DIGITS writes code_reg=buf, then CLOSING.
  - '#' short, '*', or ENTRY_TIMEOUT expiry: abort with no code change, then CLOSING.
  - code_reg returns to DEFAULT_CODE only on reset.
- Disabled: code_reg is the constant DEFAULT_CODE, there is no PROG state, and '#' in HOLD is ignored.

Decomposition:
- Package lock_pkg holds:
  - the state enum (IDLE, ENTRY, CHECK, OPENING, HOLD, CLOSING, LOCKOUT, PROG);
  - key constants KEY_STAR=4'hA, KEY_HASH=4'hB;
  - the function is_digit(key).
- One sub-module, lock_timer: loadable down-counter with load, load_val, expired. Width is derived from the maximum of the timing parameters.

Test Plan:
- Keys 1,2,3,4,# (DEFAULT_CODE) -> motor_en=1/dir=1 for MOTOR_CYCLES starting 2 cycles after '#'; then unlocked=1 for HOLD_CYCLES; then dir=0 stroke; then IDLE; fail_cnt=0.
- Keys 1,2,3,5,# three times (MAX_FAIL=3) -> fail_cnt 1,2, then locked_out=1 for LOCKOUT_CYCLES; digits during lockout are ignored; afterwards fail_cnt=0 and 1234# opens.
- Keys 1,2,# -> counted as a failure (fail_cnt=1); keys 1,2,3,4,5,# -> 5 ignored, opens.
- Keys 1,2,* then 1,2,3,4,# -> '*' clears with fail_cnt unchanged, then opens; keys 1,2 then ENTRY_TIMEOUT idle cycles -> digit_cnt=0, IDLE, fail_cnt unchanged.
- rst=0 asserted mid-OPENING -> motor_en=0 on the next edge, state IDLE, all outputs 0.
- With LOCK_CODE_PROG_EN: in HOLD enter #,9,8,7,6,# -> close stroke; afterwards 1234# fails and 9876# opens.
